// File: rtl/pe_feeder.sv
// pe_feeder: host-loaded A/B operand buffers streamed to a PE.
// Sends start, then len A words, then len B words, then done.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   hwe/hsel/haddr/    host write into A (hsel=0) or B (hsel=1)
//   hdata              buffer; accepted only while idle
//   go, max_cntr       run request and words per stream (clamped to 16)
//   aff, bff           PE side full; stalls the current word
//   start, done        single-cycle sequence pulses
//   awe/a_out          A word valid and data (0 when not valid)
//   bwe/b_out          B word valid and data (0 when not valid)
//   busy               high in every state except idle
module pe_feeder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hwe,
   input  logic        hsel,
   input  logic [3:0]  haddr,
   input  logic [15:0] hdata,
   input  logic        go,
   input  logic [7:0]  max_cntr,
   input  logic        aff,
   input  logic        bff,
   output logic        start,
   output logic        awe,
   output logic [15:0] a_out,
   output logic        bwe,
   output logic [15:0] b_out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      SENDA,
      SENDB,
      DONE
   } state_t;

   state_t      state;
   logic [4:0]  len;
   logic [3:0]  idx;
   logic [3:0]  idx_nxt;
   logic        last;

   logic [15:0] mem_a [16];
   logic [15:0] mem_b [16];

   assign idx_nxt = idx + 4'd1;
   // len is 1..16 whenever this is consulted
   assign last    = ({1'b0, idx} == (len - 5'd1));

   // Buffers are not reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (hwe && state == IDLE) begin
         if (hsel)
            mem_b[haddr] <= hdata;
         else
            mem_a[haddr] <= hdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         len   <= '0;
         idx   <= '0;
         start <= 1'b0;
         awe   <= 1'b0;
         a_out <= '0;
         bwe   <= 1'b0;
         b_out <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         start <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go && max_cntr != 8'd0) begin
                  len   <= (max_cntr > 8'd16) ? 5'd16
                                              : max_cntr[4:0];
                  idx   <= '0;
                  state <= START;
                  start <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            START: begin
               state <= SENDA;
               idx   <= '0;
               awe   <= 1'b1;
               a_out <= mem_a[0];
            end
            SENDA: begin
               if (!aff) begin
                  if (last) begin
                     // hand over to B with no idle gap
                     state <= SENDB;
                     idx   <= '0;
                     awe   <= 1'b0;
                     a_out <= '0;
                     bwe   <= 1'b1;
                     b_out <= mem_b[0];
                  end else begin
                     idx   <= idx_nxt;
                     a_out <= mem_a[idx_nxt];
                  end
               end
            end
            SENDB: begin
               if (!bff) begin
                  if (last) begin
                     state <= DONE;
                     idx   <= '0;
                     bwe   <= 1'b0;
                     b_out <= '0;
                     done  <= 1'b1;
                  end else begin
                     idx   <= idx_nxt;
                     b_out <= mem_b[idx_nxt];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 hwe  input  1  host write strobe into operand buffers.
REQ-004 hsel  input  1  buffer select: 0 = A buffer, 1 = B buffer.
REQ-005 haddr  input  4  host write index, 0..15.
REQ-006 hdata  input  16  signed host write data.
REQ-007 go  input  1  single-cycle request to run one feed sequence.
REQ-008 max_cntr  input  8  words per operand stream, sampled on an accepted go.
REQ-009 aff  input  1  PE A-side full; word on a_out not accepted while high.
REQ-010 bff  input  1  PE B-side full; word on b_out not accepted while high.
REQ-011 start  output  1  single-cycle start pulse to PE.
REQ-012 awe  output  1  A word valid.
REQ-013 a_out  output  16  signed A word to PE a_in.
REQ-014 bwe  output  1  B word valid.
REQ-015 b_out  output  16  signed B word to PE b_in.
REQ-016 busy  output  1  sequence in progress.
REQ-017 done  output  1  single-cycle completion pulse.

Function
REQ-018 Internal storage SHALL be two 16-entry x 16-bit arrays (A, B); hwe writes hdata to array[hsel][haddr] at the clock edge, only while state is IDLE; writes in other states are dropped.
REQ-019 FSM states SHALL be IDLE, START, SENDA, SENDB, DONE.
REQ-020 IDLE: go=1 with max_cntr != 0 SHALL latch len = min(max_cntr,16), clear index, go to START; go with max_cntr=0 SHALL be ignored.
REQ-021 START: start=1 for exactly one cycle, then SENDA.
REQ-022 SENDA: awe=1, a_out=A[index]; a word is accepted in a cycle where awe=1 and aff=0; on accept index increments; aff=1 holds awe=1 and a_out unchanged.
REQ-023 Acceptance of A[len-1] SHALL move to SENDB with index cleared, bwe=1 and b_out=B[0] on the very next cycle (no gap).
REQ-024 SENDB: same rules as REQ-022 using bwe, b_out, bff; acceptance of B[len-1] moves to DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Latency: go sampled at edge N -> start=1 in cycle N+1 -> awe=1 with A[0] in cycle N+2; unstalled sequence occupies 2*len+2 cycles after go.
REQ-028 a_out SHALL be 0 whenever awe=0; b_out SHALL be 0 whenever bwe=0; awe and bwe SHALL never be 1 simultaneously.
REQ-029 All outputs SHALL be registered; aff/bff only gate the index advance, never combinationally drive outputs.
REQ-030 go while busy=1 SHALL be ignored; max_cntr changes after acceptance SHALL not affect the running sequence.
REQ-031 max_cntr values 17..255 SHALL clamp to 16 words per stream.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, index 0, len 0, and start, awe, a_out, bwe, b_out, busy, done all to 0, including mid-sequence.
REQ-033 Buffer contents SHALL not be cleared by reset.

Verification
REQ-034 Load A={1,2,3,4}, B={5,6,7,8}, max_cntr=4, go, aff=bff=0 -> start 1 cycle, then awe with 1,2,3,4 on 4 consecutive cycles, then bwe with 5,6,7,8, then done=1; busy high 10 cycles.
REQ-035 Same load, aff=1 for 3 cycles while a_out=2 -> a_out stays 2 with awe=1 for 3 extra cycles, then 3,4 follow; total sequence 3 cycles longer.
REQ-036 max_cntr=0 with go -> no start, busy stays 0; max_cntr=200 -> exactly 16 A and 16 B words sent.
REQ-037 go and hwe (A[0]=99) asserted during SENDB -> no restart, A[0] unchanged, next run sends original A[0].
REQ-038 rst_n low while awe=1 with a_out=3 -> all outputs 0 immediately; after release, new go replays from A[0]=1.
